// File: rtl/tick_gen_multi.sv
// tick_gen_multi: 1 us base-tick prescaler feeding NUM_CH independent
// periodic / one-shot channel timers, each counting base ticks.
//
// Ports:
//   clk          system clock, all logic on rising edge
//   rst          synchronous active-high reset, overrides everything
//   en           global run enable for prescaler (and hence all channels)
//   cfg_we       one-cycle channel configuration write strobe
//   cfg_ch       channel index for cfg_we (indices >= NUM_CH are ignored)
//   cfg_period   channel period in us; 0 stops the channel
//   cfg_oneshot  0 = periodic, 1 = one-shot
//   us_tick      registered 1-cycle pulse every CYC_PER_US enabled cycles
//   ch_tick      registered 1-cycle pulse per channel on period expiry
//   ch_busy      registered per-channel armed/counting flag
module tick_gen_multi #(
   parameter int unsigned CYC_PER_US = 20,
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned CH_W       = 1,
   parameter int unsigned PER_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [PER_W-1:0]  cfg_period,
   input  logic              cfg_oneshot,
   output logic              us_tick,
   output logic [NUM_CH-1:0] ch_tick,
   output logic [NUM_CH-1:0] ch_busy
);

   localparam int unsigned P_W = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
   localparam logic [P_W-1:0] P_MAX = P_W'(CYC_PER_US - 1);

   logic [P_W-1:0]   pre_cnt;
   logic [PER_W-1:0] per [NUM_CH];
   logic [PER_W-1:0] cnt [NUM_CH];
   logic [NUM_CH-1:0] mode;
   logic [NUM_CH-1:0] wr_hit_c;

   // Decode write strobe per channel; out-of-range indices match nothing.
   always_comb begin
      wr_hit_c = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         wr_hit_c[i] = cfg_we && (32'(cfg_ch) == i);
      end
   end

   // Prescaler: wraps every CYC_PER_US enabled cycles, holds when en=0.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt <= '0;
         us_tick <= 1'b0;
      end else begin
         us_tick <= 1'b0;
         if (en) begin
            if (pre_cnt == P_MAX) begin
               pre_cnt <= '0;
               us_tick <= 1'b1;
            end else begin
               pre_cnt <= pre_cnt + P_W'(1);
            end
         end
      end
   end

   // Channel timers; a write on the same edge as us_tick wins and drops that tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_tick <= '0;
         ch_busy <= '0;
         mode    <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            per[i] <= '0;
            cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_tick[i] <= 1'b0;
            if (wr_hit_c[i]) begin
               per[i]     <= cfg_period;
               mode[i]    <= cfg_oneshot;
               cnt[i]     <= '0;
               ch_busy[i] <= |cfg_period;
            end else if (us_tick && ch_busy[i]) begin
               // busy implies per != 0, so per-1 cannot underflow here
               if (cnt[i] == per[i] - PER_W'(1)) begin
                  cnt[i]     <= '0;
                  ch_tick[i] <= 1'b1;
                  if (mode[i]) begin
                     ch_busy[i] <= 1'b0;
                  end
               end else begin
                  cnt[i] <= cnt[i] + PER_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Testbench for tick_gen_multi: directed scenarios followed by a random
// phase, every cycle compared against a behavioural reference model.
`timescale 1ns/1ps
module tb_tick_gen_multi;

   localparam int unsigned CYC = 20;
   localparam int unsigned NCH = 2;
   localparam int unsigned CHW = 2;
   localparam int unsigned PW  = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           en = 1'b0;
   logic           cfg_we = 1'b0;
   logic [CHW-1:0] cfg_ch = '0;
   logic [PW-1:0]  cfg_period = '0;
   logic           cfg_oneshot = 1'b0;
   logic           us_tick;
   logic [NCH-1:0] ch_tick;
   logic [NCH-1:0] ch_busy;

   int checks = 0;
   int errors = 0;

   // Reference model: enabled-cycle total, and per channel the number of
   // base ticks still to go before the next expiry.
   int unsigned en_cycles;
   bit          m_us;
   bit [NCH-1:0] m_tick;
   bit [NCH-1:0] m_busy;
   int          m_rem [NCH];
   int          m_per [NCH];
   bit          m_one [NCH];

   tick_gen_multi #(
      .CYC_PER_US (CYC),
      .NUM_CH     (NCH),
      .CH_W       (CHW),
      .PER_W      (PW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_period  (cfg_period),
      .cfg_oneshot (cfg_oneshot),
      .us_tick     (us_tick),
      .ch_tick     (ch_tick),
      .ch_busy     (ch_busy)
   );

   always #25 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_edge();
      bit [NCH-1:0] nt;
      bit           nu;
      if (rst) begin
         en_cycles = 0;
         m_us = 1'b0;
         m_tick = '0;
         m_busy = '0;
         for (int c = 0; c < int'(NCH); c++) begin
            m_rem[c] = 0;
            m_per[c] = 0;
            m_one[c] = 1'b0;
         end
      end else begin
         nt = '0;
         for (int c = 0; c < int'(NCH); c++) begin
            if (cfg_we && int'(cfg_ch) == c) begin
               m_per[c]  = int'(cfg_period);
               m_one[c]  = cfg_oneshot;
               m_rem[c]  = int'(cfg_period);
               m_busy[c] = (cfg_period != 0);
            end else if (m_us && m_busy[c]) begin
               m_rem[c]--;
               if (m_rem[c] == 0) begin
                  nt[c] = 1'b1;
                  if (m_one[c]) m_busy[c] = 1'b0;
                  else          m_rem[c] = m_per[c];
               end
            end
         end
         nu = 1'b0;
         if (en) begin
            en_cycles++;
            nu = (en_cycles % CYC) == 0;
         end
         m_us = nu;
         m_tick = nt;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("us_tick", 32'(us_tick), 32'(m_us));
      check("ch_tick", 32'(ch_tick), 32'(m_tick));
      check("ch_busy", 32'(ch_busy), 32'(m_busy));
   endtask

   task automatic wr(input int ch, input int per, input bit os);
      cfg_we = 1'b1;
      cfg_ch = CHW'(ch);
      cfg_period = PW'(per);
      cfg_oneshot = os;
      tick();
      cfg_we = 1'b0;
   endtask

   initial begin
      int n;
      int pulses;
      bit found;

      // Reset with en high: all outputs stay low.
      rst = 1'b1;
      en  = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("rst_outputs", {us_tick, ch_tick, ch_busy}, 32'd0);

      // First base tick arrives exactly CYC cycles after release.
      rst = 1'b0;
      found = 1'b0;
      n = 0;
      for (int i = 1; i <= 40 && !found; i++) begin
         tick();
         if (us_tick) begin
            found = 1'b1;
            n = i;
         end
      end
      check("first_us_latency", n, CYC);

      // Periodic channel 0, P=3 (written on a us_tick edge).
      wr(0, 3, 1'b0);
      pulses = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (ch_tick[0]) pulses++;
      end
      check("ch0_p3_pulses", pulses, 3);

      // One-shot channel 1, P=2: a single pulse, then idle.
      wr(1, 2, 1'b1);
      pulses = 0;
      for (int i = 0; i < 250; i++) begin
         tick();
         if (ch_tick[1]) pulses++;
      end
      check("ch1_oneshot_pulses", pulses, 1);
      check("ch1_oneshot_busy", 32'(ch_busy[1]), 32'd0);

      // en dropped for 37 cycles, with a write accepted while stopped.
      for (int i = 0; i < 17; i++) tick();
      en = 1'b0;
      for (int i = 0; i < 18; i++) tick();
      wr(1, 1, 1'b0);
      check("wr_during_en0", 32'(ch_busy[1]), 32'd1);
      for (int i = 0; i < 18; i++) tick();
      en = 1'b1;
      for (int i = 0; i < 150; i++) tick();

      // Write on the same edge as us_tick, out-of-range write, then stop.
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (m_us) found = 1'b1;
         else tick();
      end
      check("us_align_found", 32'(found), 32'd1);
      wr(0, 4, 1'b0);
      wr(3, 7, 1'b1);
      for (int i = 0; i < 120; i++) tick();
      wr(0, 0, 1'b0);
      pulses = 0;
      for (int i = 0; i < 150; i++) begin
         tick();
         if (ch_tick[0]) pulses++;
      end
      check("ch0_stopped_pulses", pulses, 0);
      check("ch0_stopped_busy", 32'(ch_busy[0]), 32'd0);

      // Max period, then reset mid-count on both channels.
      wr(0, 255, 1'b0);
      wr(1, 5, 1'b0);
      for (int i = 0; i < 53; i++) tick();
      rst = 1'b1;
      tick();
      check("midrst_outputs", {us_tick, ch_tick, ch_busy}, 32'd0);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (ch_tick != 0) pulses++;
      end
      check("post_rst_pulses", pulses, 0);

      // Random phase.
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 499) == 0);
         cfg_we = ($urandom_range(0, 59) == 0);
         cfg_ch = CHW'($urandom_range(0, 3));
         cfg_period = ($urandom_range(0, 15) == 0) ? PW'(255) : PW'($urandom_range(0, 6));
         cfg_oneshot = 1'($urandom_range(0, 1));
         tick();
      end
      rst = 1'b0;
      cfg_we = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tick_gen_multi.md
TICK_GEN_MULTI -- requirements
Module: tick_gen_multi

Interface
REQ-001 The block SHALL have parameter CYC_PER_US, default 20, meaning clk cycles per 1 us base tick (>= 2).
REQ-002 The block SHALL have parameter NUM_CH, default 2, meaning number of independent period channels (1..16).
REQ-003 The block SHALL have parameter CH_W, default 1, meaning width of cfg_ch (2^CH_W >= NUM_CH).
REQ-004 The block SHALL have parameter PER_W, default 8, meaning width of channel period and counter, in us units.
REQ-005 The block SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 The block SHALL have port en  input  1  global run enable for prescaler and channel counters.
REQ-008 The block SHALL have port cfg_we  input  1  one-cycle configuration write strobe.
REQ-009 The block SHALL have port cfg_ch  input  CH_W  channel index addressed by cfg_we.
REQ-010 The block SHALL have port cfg_period  input  PER_W  period in us; 0 means stop the channel.
REQ-011 The block SHALL have port cfg_oneshot  input  1  mode: 0 periodic, 1 one-shot.
REQ-012 The block SHALL have port us_tick  output  1  registered 1-cycle pulse, once per CYC_PER_US enabled cycles.
REQ-013 The block SHALL have port ch_tick  output  NUM_CH  registered 1-cycle pulse per channel on period expiry.
REQ-014 The block SHALL have port ch_busy  output  NUM_CH  channel armed/counting flag, registered.

Function
REQ-015 Prescaler p SHALL count 0..CYC_PER_US-1 on each edge with en=1, and hold its value when en=0.
REQ-016 On an edge with en=1 and p==CYC_PER_US-1: p SHALL go to 0 and us_tick SHALL be 1 for the following cycle; on every other edge us_tick SHALL be 0.
REQ-017 Each channel SHALL hold period P, mode M, count C (PER_W bits), and active flag A; ch_busy[i]=A[i].
REQ-018 cfg_we with cfg_ch<NUM_CH SHALL load P=cfg_period and M=cfg_oneshot, clear C to 0, and set A=(cfg_period!=0) on that edge; cfg_we SHALL be accepted regardless of en.
REQ-019 cfg_we with cfg_ch>=NUM_CH SHALL be ignored with no state change.
REQ-020 On an edge with us_tick=1 and A[i]=1 and no write to channel i: if C==P-1 then C<=0 and ch_tick[i]<=1, otherwise C<=C+1 and ch_tick[i]<=0.
REQ-021 On expiry in one-shot mode (M=1), A SHALL clear on the same edge that sets ch_tick; P SHALL be retained.
REQ-022 ch_tick[i] SHALL be 0 on every edge not satisfying REQ-020's expiry condition; channels with A=0 SHALL hold C and never pulse.
REQ-023 Latency: with en held 1, channel i SHALL pulse one cycle after the P-th us_tick following its write, then every P us in periodic mode.
REQ-024 Simultaneous cfg_we to channel i and us_tick SHALL apply the write only; that us_tick SHALL NOT be counted by channel i; other channels SHALL count normally.
REQ-025 P=1 SHALL give a ch_tick one cycle after every us_tick; P=2^PER_W-1 is the maximum period; C SHALL never exceed P-1.
REQ-026 When en=0, us_tick SHALL be 0, so all C values hold; a pending one-cycle ch_tick already registered SHALL still complete.

Reset
REQ-027 While rst=1 at an edge: p=0, us_tick=0, ch_tick=0, ch_busy=0, all P=0, M=0, C=0, and A=0; rst SHALL override cfg_we and en.
REQ-028 Reset asserted mid-count SHALL abort all channels; after release, no ch_tick occurs until a new cfg_we.

Verification (CYC_PER_US=20, NUM_CH=2, PER_W=8, clk period 50 ns)
REQ-029 Stimulus: rst=1 for 3 cycles, en=1. Required response: all outputs 0 during reset; after release, us_tick is high at cycles 20, 40, 60, ... with width exactly 1 cycle.
REQ-030 Stimulus: write ch0 P=3 periodic after reset. Required response: ch_tick[0] one cycle after the 3rd, 6th, 9th us_tick (every 60 cycles); ch_busy[0]=1 throughout.
REQ-031 Stimulus: write ch1 P=2 one-shot. Required response: exactly one ch_tick[1] one cycle after the 2nd us_tick; ch_busy[1] falls on the same edge; no further pulses over 200 cycles.
REQ-032 Stimulus: drop en for 37 cycles mid-count. Required response: all subsequent us_tick and ch_tick pulses shift by exactly 37 cycles; cfg write during en=0 is accepted.
REQ-033 Stimulus: write ch0 P=4 on the same edge as us_tick, then write cfg_ch=3, then write ch0 P=0. Required response: first ch_tick[0] occurs after 4 further us_ticks; the cfg_ch=3 write changes nothing; the P=0 write clears ch_busy[0] with no further pulses.
REQ-034 Stimulus: assert rst for 1 cycle with both channels mid-count. Required response: all outputs 0 next cycle; no ch_tick over 300 cycles without a new cfg write.
